// File: rtl/top_ting.sv
// top_ting: elliptic-curve scalar multiplier Q = k*P over GF(p), 32-bit operands.
// Operands arrive as eight least-significant-first nibbles per operand. The point
// arithmetic uses affine coordinates and left-to-right double-and-add. Two small
// engines do the field work: a shift-add modular multiplier (32 cycles) and a
// binary extended-Euclid inverter (at most about 64 cycles).
module top_ting (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] a,
  input  logic [3:0] prime,
  input  logic [3:0] k,
  input  logic [3:0] Px,
  input  logic [3:0] Py,
  output logic [3:0] kPx,
  output logic [3:0] kPy,
  output logic       done
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;
  typedef enum logic [3:0] {
    S_DBL, S_DINV, S_DSQ, S_LAM, S_X3, S_Y3, S_ADDCHK, S_AINV, S_NEXT
  } step_t;

  // x + y mod p, with x, y < p
  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] p);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[DATA_W-1:0];
  endfunction

  // x - y mod p, with x, y < p; the wrap of the 32-bit sum lands on the true value
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] p);
    return (x >= y) ? (x - y) : (x - y + p);
  endfunction

  // x / 2 mod p for odd p: add p first when x is odd
  function automatic logic [DATA_W-1:0] mod_half(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] p);
    logic [DATA_W:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, p} : {(DATA_W+1){1'b0}});
    return s[DATA_W:1];
  endfunction

  state_t state_q, state_d;
  step_t  step_q, step_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] bit_q, bit_d;
  logic       phase_q, phase_d;   // 0: doubling half of the bit, 1: addition half
  logic [DATA_W-1:0] a_q, a_d, p_q, p_d, k_q, k_d, px_q, px_d, py_q, py_d;
  logic [DATA_W-1:0] qx_q, qx_d, qy_q, qy_d;
  logic              qinf_q, qinf_d;
  logic [DATA_W-1:0] xo_q, xo_d, tinv_q, tinv_d, lam_q, lam_d, tmp_q, tmp_d;
  logic [DATA_W-1:0] ma_q, ma_d, mb_q, mb_d, macc_q, macc_d;
  logic [4:0]        mcnt_q, mcnt_d;
  logic [DATA_W-1:0] iu_q, iu_d, iv_q, iv_d, ix1_q, ix1_d, ix2_q, ix2_d;
  logic [3:0]        kpx_q, kpx_d, kpy_q, kpy_d;
  logic              done_q, done_d;

  logic              mul_active, mul_last, inv_active, inv_done;
  logic [DATA_W-1:0] mul_next, inv_res, x3;

  // Engine status: one multiplier bit per cycle (MSB first), inverter termination
  always_comb begin
    mul_active = (state_q == COMPUTE) &&
                 (step_q == S_DSQ || step_q == S_LAM || step_q == S_X3 || step_q == S_Y3);
    mul_last   = (mcnt_q == 5'd31);
    mul_next   = mod_add(mod_add(macc_q, macc_q, p_q), mb_q[DATA_W-1] ? ma_q : '0, p_q);
    inv_active = (state_q == COMPUTE) && (step_q == S_DINV || step_q == S_AINV);
    inv_done   = (iu_q == 32'd1) || (iv_q == 32'd1);
    inv_res    = (iu_q == 32'd1) ? ix1_q : ix2_q;
    x3         = mod_sub(mod_sub(mul_next, qx_q, p_q), xo_q, p_q);
  end

  // Next-state logic for the control FSM, operand shift-in and the point sequencer
  always_comb begin
    state_d = state_q;  step_d = step_q;  cnt_d = cnt_q;  bit_d = bit_q;
    phase_d = phase_q;
    a_d = a_q;  p_d = p_q;  k_d = k_q;  px_d = px_q;  py_d = py_q;
    qx_d = qx_q;  qy_d = qy_q;  qinf_d = qinf_q;
    xo_d = xo_q;  tinv_d = tinv_q;  lam_d = lam_q;  tmp_d = tmp_q;
    ma_d = ma_q;  mb_d = mb_q;  macc_d = macc_q;  mcnt_d = mcnt_q;
    iu_d = iu_q;  iv_d = iv_q;  ix1_d = ix1_q;  ix2_d = ix2_q;
    kpx_d = '0;  kpy_d = '0;  done_d = 1'b0;

    if (mul_active) begin
      macc_d = mul_next;
      mb_d   = mb_q << 1;
      mcnt_d = mcnt_q + 5'd1;
    end

    // One inverter step removes at least one bit from u or v
    if (inv_active && !inv_done) begin
      if (!iu_q[0]) begin
        iu_d  = iu_q >> 1;
        ix1_d = mod_half(ix1_q, p_q);
      end else if (!iv_q[0]) begin
        iv_d  = iv_q >> 1;
        ix2_d = mod_half(ix2_q, p_q);
      end else if (iu_q >= iv_q) begin
        iu_d  = (iu_q - iv_q) >> 1;
        ix1_d = mod_half(mod_sub(ix1_q, ix2_q, p_q), p_q);
      end else begin
        iv_d  = (iv_q - iu_q) >> 1;
        ix2_d = mod_half(mod_sub(ix2_q, ix1_q, p_q), p_q);
      end
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        a_d  = {a, a_q[DATA_W-1:4]};
        p_d  = {prime, p_q[DATA_W-1:4]};
        k_d  = {k, k_q[DATA_W-1:4]};
        px_d = {Px, px_q[DATA_W-1:4]};
        py_d = {Py, py_q[DATA_W-1:4]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = COMPUTE;
          step_d  = S_DBL;
          bit_d   = 5'd31;
          phase_d = 1'b0;
          qinf_d  = 1'b1;
          qx_d    = '0;
          qy_d    = '0;
        end
      end
      COMPUTE: begin
        case (step_q)
          S_DBL: begin
            if (qinf_q || qy_q == '0) begin
              qinf_d = 1'b1;
              step_d = phase_q ? S_NEXT : S_ADDCHK;
            end else begin
              xo_d  = qx_q;
              iu_d  = mod_add(qy_q, qy_q, p_q);
              iv_d  = p_q;
              ix1_d = 32'd1;
              ix2_d = '0;
              step_d = S_DINV;
            end
          end
          S_DINV: begin
            if (inv_done) begin
              tinv_d = inv_res;
              ma_d = qx_q;  mb_d = qx_q;  macc_d = '0;  mcnt_d = '0;
              step_d = S_DSQ;
            end
          end
          S_DSQ: begin
            if (mul_last) begin
              ma_d = mod_add(mod_add(mod_add(mul_next, mul_next, p_q), mul_next, p_q), a_q, p_q);
              mb_d = tinv_q;  macc_d = '0;  mcnt_d = '0;
              step_d = S_LAM;
            end
          end
          S_LAM: begin
            if (mul_last) begin
              lam_d = mul_next;
              ma_d = mul_next;  mb_d = mul_next;  macc_d = '0;  mcnt_d = '0;
              step_d = S_X3;
            end
          end
          S_X3: begin
            if (mul_last) begin
              tmp_d = x3;
              ma_d = lam_q;  mb_d = mod_sub(qx_q, x3, p_q);  macc_d = '0;  mcnt_d = '0;
              step_d = S_Y3;
            end
          end
          S_Y3: begin
            if (mul_last) begin
              qx_d   = tmp_q;
              qy_d   = mod_sub(mul_next, qy_q, p_q);
              qinf_d = 1'b0;
              step_d = phase_q ? S_NEXT : S_ADDCHK;
            end
          end
          S_ADDCHK: begin
            phase_d = 1'b1;
            if (!k_q[bit_q]) begin
              step_d = S_NEXT;
            end else if (qinf_q) begin
              qx_d = px_q;  qy_d = py_q;  qinf_d = 1'b0;
              step_d = S_NEXT;
            end else if (qx_q == px_q) begin
              // Q == P degenerates to a doubling; Q == -P gives infinity
              if (qy_q == py_q) begin
                step_d = S_DBL;
              end else begin
                qinf_d = 1'b1;
                step_d = S_NEXT;
              end
            end else begin
              xo_d  = px_q;
              iu_d  = mod_sub(px_q, qx_q, p_q);
              iv_d  = p_q;
              ix1_d = 32'd1;
              ix2_d = '0;
              step_d = S_AINV;
            end
          end
          S_AINV: begin
            if (inv_done) begin
              ma_d = mod_sub(py_q, qy_q, p_q);  mb_d = inv_res;  macc_d = '0;  mcnt_d = '0;
              step_d = S_LAM;
            end
          end
          S_NEXT: begin
            if (bit_q == 5'd0) begin
              state_d = OUTPUT;
              done_d  = 1'b1;
              cnt_d   = '0;
              if (qinf_q) begin
                qx_d = '0;
                qy_d = '0;
              end
            end else begin
              bit_d   = bit_q - 5'd1;
              phase_d = 1'b0;
              step_d  = S_DBL;
            end
          end
          default: step_d = S_NEXT;
        endcase
      end
      OUTPUT: begin
        if (cnt_q != 4'd8) begin
          kpx_d = qx_q[3:0];
          kpy_d = qy_q[3:0];
          qx_d  = qx_q >> 4;
          qy_d  = qy_q >> 4;
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation and clears every register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;  step_q <= S_DBL;  cnt_q <= '0;  bit_q <= '0;  phase_q <= 1'b0;
      a_q <= '0;  p_q <= '0;  k_q <= '0;  px_q <= '0;  py_q <= '0;
      qx_q <= '0;  qy_q <= '0;  qinf_q <= 1'b0;
      xo_q <= '0;  tinv_q <= '0;  lam_q <= '0;  tmp_q <= '0;
      ma_q <= '0;  mb_q <= '0;  macc_q <= '0;  mcnt_q <= '0;
      iu_q <= '0;  iv_q <= '0;  ix1_q <= '0;  ix2_q <= '0;
      kpx_q <= '0;  kpy_q <= '0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  step_q <= step_d;  cnt_q <= cnt_d;  bit_q <= bit_d;
      phase_q <= phase_d;
      a_q <= a_d;  p_q <= p_d;  k_q <= k_d;  px_q <= px_d;  py_q <= py_d;
      qx_q <= qx_d;  qy_q <= qy_d;  qinf_q <= qinf_d;
      xo_q <= xo_d;  tinv_q <= tinv_d;  lam_q <= lam_d;  tmp_q <= tmp_d;
      ma_q <= ma_d;  mb_q <= mb_d;  macc_q <= macc_d;  mcnt_q <= mcnt_d;
      iu_q <= iu_d;  iv_q <= iv_d;  ix1_q <= ix1_d;  ix2_q <= ix2_d;
      kpx_q <= kpx_d;  kpy_q <= kpy_d;  done_q <= done_d;
    end
  end

  assign kPx  = kpx_q;
  assign kPy  = kpy_q;
  assign done = done_q;

endmodule

// File: tb/tb_top_ting.sv
// Directed bench for top_ting: small curve p=17 with hand-derived multiples,
// aborts, and a 32-bit prime checked against an independent behavioural model.
module tb_top_ting;

  logic       i_clk = 1'b0;
  logic       i_rst, i_start;
  logic [3:0] a, prime, k, Px, Py;
  logic [3:0] kPx, kPy;
  logic       done;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  top_ting dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .a(a), .prime(prime), .k(k), .Px(Px), .Py(Py),
    .kPx(kPx), .kPy(kPy), .done(done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- behavioural golden model (64-bit products, Fermat inverse)
  function automatic logic [31:0] gmul(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] p);
    logic [63:0] t;
    t = {32'b0, x} * {32'b0, y};
    return 32'(t % {32'b0, p});
  endfunction

  function automatic logic [31:0] gadd(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] p);
    logic [63:0] t;
    t = {32'b0, x} + {32'b0, y};
    return 32'(t % {32'b0, p});
  endfunction

  function automatic logic [31:0] gsub(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] p);
    logic [63:0] t;
    t = {32'b0, x} + {32'b0, p} - {32'b0, y};
    return 32'(t % {32'b0, p});
  endfunction

  function automatic logic [31:0] gpow(input logic [31:0] x, input logic [31:0] e,
                                       input logic [31:0] p);
    logic [31:0] r, b;
    r = 32'd1;
    b = x;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = gmul(r, b, p);
      b = gmul(b, b, p);
    end
    return r;
  endfunction

  task automatic gpt_add(input logic [31:0] x1, input logic [31:0] y1, input bit i1,
                         input logic [31:0] x2, input logic [31:0] y2, input bit i2,
                         input logic [31:0] p, input logic [31:0] av,
                         output logic [31:0] x3, output logic [31:0] y3, output bit i3);
    logic [31:0] lam;
    if (i1) begin x3 = x2; y3 = y2; i3 = i2; end
    else if (i2) begin x3 = x1; y3 = y1; i3 = i1; end
    else if (x1 == x2 && (y1 != y2 || y1 == 0)) begin x3 = 0; y3 = 0; i3 = 1; end
    else begin
      if (x1 == x2)
        lam = gmul(gadd(gmul(3, gmul(x1, x1, p), p), av, p),
                   gpow(gadd(y1, y1, p), p - 2, p), p);
      else
        lam = gmul(gsub(y2, y1, p), gpow(gsub(x2, x1, p), p - 2, p), p);
      x3 = gsub(gsub(gmul(lam, lam, p), x1, p), x2, p);
      y3 = gsub(gmul(lam, gsub(x1, x3, p), p), y1, p);
      i3 = 0;
    end
  endtask

  // Right-to-left ladder, reporting infinity as (0,0)
  task automatic gpt_mul(input logic [31:0] av, input logic [31:0] p, input logic [31:0] kv,
                         input logic [31:0] xv, input logic [31:0] yv,
                         output logic [31:0] rx, output logic [31:0] ry);
    logic [31:0] ax, ay, bx, by, tx, ty;
    bit ai, bi, ti;
    ax = 0; ay = 0; ai = 1;
    bx = xv; by = yv; bi = 0;
    for (int i = 0; i < 32; i++) begin
      if (kv[i]) begin
        gpt_add(ax, ay, ai, bx, by, bi, p, av, tx, ty, ti);
        ax = tx; ay = ty; ai = ti;
      end
      gpt_add(bx, by, bi, bx, by, bi, p, av, tx, ty, ti);
      bx = tx; by = ty; bi = ti;
    end
    rx = ai ? 32'd0 : ax;
    ry = ai ? 32'd0 : ay;
  endtask

  // ---------------- stimulus helpers
  task automatic do_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    step();
    i_rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] av, input logic [31:0] pv, input logic [31:0] kv,
                      input logic [31:0] xv, input logic [31:0] yv);
    i_start = 1'b1;
    a = 4'hA; prime = 4'h1; k = 4'hF; Px = 4'h7; Py = 4'h9;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = av[i*4 +: 4]; prime = pv[i*4 +: 4]; k = kv[i*4 +: 4];
      Px = xv[i*4 +: 4]; Py = yv[i*4 +: 4];
      step();
    end
    a = 4'hF; prime = 4'hE; k = 4'h5; Px = 4'h3; Py = 4'hC;
  endtask

  task automatic run_check(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                           input int budget, input bit pulse);
    int  cyc;
    bit  got, extra;
    cyc = 0;
    got = 0;
    extra = 0;
    while (!got && cyc < budget) begin
      if (pulse && cyc == 10) i_start = 1'b1;
      step();
      i_start = 1'b0;
      cyc++;
      if (done === 1'b1) got = 1;
    end
    chk($sformatf("%s done_seen", tag), 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("%s out_at_D", tag), {24'b0, kPx, kPy}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        step();
        if (done !== 1'b0) extra = 1;
        chk($sformatf("%s x_nib%0d", tag, i), 32'(kPx), 32'(ex[i*4 +: 4]));
        chk($sformatf("%s y_nib%0d", tag, i), 32'(kPy), 32'(ey[i*4 +: 4]));
      end
      chk($sformatf("%s done_once", tag), 32'(extra), 32'd0);
      step();
      chk($sformatf("%s out_after", tag), {23'b0, done, kPx, kPy}, 32'd0);
    end
  endtask

  int          kk [10] = '{1, 2, 3, 9, 10, 19, 0, 20, 4, 7};
  logic [31:0] exs[10] = '{5, 6, 10, 7, 7, 0, 0, 5, 3, 0};
  logic [31:0] eys[10] = '{1, 3, 6, 6, 11, 0, 0, 1, 1, 6};

  initial begin
    logic [31:0] gx, gy;
    bit          quiet;
    i_rst = 1'b1; i_start = 1'b0;
    a = '0; prime = '0; k = '0; Px = '0; Py = '0;
    step();
    step();
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out", {24'b0, kPx, kPy}, 32'd0);
    i_rst = 1'b0;

    // Ten patterns on y^2 = x^3 + 2x + b over GF(17), P = (5,1), order 19
    for (int t = 0; t < 10; t++) begin
      do_reset();
      load(32'd2, 32'd17, 32'(kk[t]), 32'd5, 32'd1);
      run_check($sformatf("p17_k%0d", kk[t]), exs[t], eys[t], 20000, (t == 3));
    end

    // Abort mid-computation: no done pulse, outputs held at zero
    do_reset();
    load(32'd2, 32'd17, 32'hFFFF_FFFF, 32'd5, 32'd1);
    repeat (200) step();
    i_rst = 1'b1;
    step();
    chk("abort_in_reset", {23'b0, done, kPx, kPy}, 32'd0);
    i_rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (done !== 1'b0 || kPx !== 4'h0 || kPy !== 4'h0) quiet = 0;
    end
    chk("abort_quiet", 32'(quiet), 32'd1);
    load(32'd2, 32'd17, 32'd3, 32'd5, 32'd1);
    run_check("after_abort_k3", 32'd10, 32'd6, 20000, 1'b0);

    // Reset then start in the very first cycle after deassertion
    do_reset();
    load(32'd2, 32'd17, 32'd10, 32'd5, 32'd1);
    run_check("start_after_rst_k10", 32'd7, 32'd11, 20000, 1'b0);

    // Full-width prime 2^32-5; any point lies on the curve with the implied b
    gpt_mul(32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0BAD_CAFE, gx, gy);
    do_reset();
    load(32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0BAD_CAFE);
    run_check("p32_kFFFFFFFF", gx, gy, 20000, 1'b0);

    gpt_mul(32'hFFFF_FF00, 32'hFFFF_FFFB, 32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_0003, gx, gy);
    do_reset();
    load(32'hFFFF_FF00, 32'hFFFF_FFFB, 32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_0003);
    run_check("p32_kDEADBEEF", gx, gy, 20000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/top_ting.md
TOP_TING -- requirements
Module: top_ting

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port i_start, input, 1 bit: one-cycle pulse that opens an operand load.
REQ-004 SHALL have ports a, prime, k, Px, Py, inputs, 4 bits each: operand nibble streams for curve coefficient a, field prime p, scalar k, and base point x/y.
REQ-005 SHALL have ports kPx, kPy, outputs, 4 bits each: result nibble streams for x(kP) and y(kP).
REQ-006 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-007 SHALL compute Q = k*P on the curve y^2 = x^3 + a*x + b over GF(p); b is implied by P and never used.
REQ-008 SHALL treat all operands as 32-bit unsigned values; p is an odd prime, 3 <= p < 2^32; a, Px, Py < p; P lies on the curve; k is any 32-bit value.
REQ-009 States: IDLE, LOAD, COMPUTE, OUTPUT.
REQ-010 IDLE: on i_start=1, go to LOAD; nibble inputs are ignored in the i_start cycle.
REQ-011 LOAD: the 8 cycles after the i_start cycle each carry one nibble per operand, least-significant first (cycle 1 = bits[3:0] … cycle 8 = bits[31:28]); then go to COMPUTE.
REQ-012 COMPUTE: left-to-right double-and-add over all 32 bits of k using affine coordinates; all intermediates reduced mod p, with no overflow of 32x32 products (64-bit product or shift-add modular multiply).
REQ-013 Doubling: lambda = (3x^2 + a) * (2y)^-1 mod p; if y = 0, the result is infinity.
REQ-014 Addition: lambda = (y2 - y1) * (x2 - x1)^-1 mod p; if x1 = x2 and y1 = y2, use doubling; if x1 = x2 and y1 != y2, the result is infinity; infinity + R = R.
REQ-015 Modular inverse by binary extended Euclid or Fermat (z^(p-2)); multi-cycle is allowed.
REQ-016 COMPUTE SHALL finish within 20000 cycles of the last LOAD cycle.
REQ-017 An infinity result (including k = 0 or k a multiple of the order of P) SHALL be reported as x = 0, y = 0.
REQ-018 On finishing COMPUTE, done = 1 for exactly one cycle (cycle D); then go to OUTPUT.
REQ-019 OUTPUT: in cycles D+1 … D+8, kPx/kPy = Qx/Qy bits[3:0], [7:4], … [31:28] in turn; then return to IDLE.
REQ-020 kPx/kPy = 0 in every cycle outside the OUTPUT window.
REQ-021 i_start SHALL be ignored in LOAD, COMPUTE and OUTPUT.
REQ-022 Inputs may hold stale values after LOAD; they SHALL NOT affect the computation.

Reset
REQ-023 When i_rst = 1 at a rising edge, the block SHALL go to IDLE with done = 0, kPx = 0, kPy = 0, and clear all operand and accumulator registers.
REQ-024 Reset asserted during LOAD, COMPUTE or OUTPUT SHALL abort the operation; done SHALL NOT pulse for the aborted operation.
REQ-025 A new i_start is accepted in the first cycle after reset deasserts.

Verification
REQ-026 p=17, a=2, P=(5,1), k=1 -> done, then nibble streams give Q=(5,1).
REQ-027 Same curve, k=2 -> (6,3); k=3 -> (10,6); k=9 -> (7,6); k=10 -> (7,11).
REQ-028 Same curve, k=19 (order of P) -> (0,0); k=0 -> (0,0); k=20 -> (5,1).
REQ-029 Back-to-back: ten patterns, each run as reset, load, done, 8 output cycles; each output matches its golden 32-bit values nibble-by-nibble at D+1…D+8.
REQ-030 Reset mid-COMPUTE -> no done pulse and outputs 0; a following full load with k=3 -> (10,6).
REQ-031 32-bit prime p=0xFFFFFFFB with a valid on-curve P -> result equals a software golden model; done arrives within 20000 cycles.
